// File: rtl/aux_replay_sched.sv
// Receive-side aux scheduler: pops stamped aux FIFO words when the pixel position
// matches their stamp and replays them as registered ADE beats. AUX_STATS_EN adds drop/underrun counters.
module aux_replay_sched #(
  parameter int POS_W     = 16,
  parameter int BURST_LEN = 32,
  parameter int CNT_W     = 4
) (
  input  logic             fifo_clk,
  input  logic             rstbtn_n,
  input  logic             rxvde,
  input  logic             vid_start,
  input  logic             vfifo_empty,
  input  logic [POS_W+8:0] ax_dout,
  input  logic             ax_empty,
  output logic             ax_rd_en,
  output logic             ade,
  output logic [8:0]       aux_out,
  output logic [CNT_W-1:0] ade_num,
  output logic             drop_pulse,
  output logic             underrun_pulse,
  output logic [15:0]      drop_cnt,
  output logic [15:0]      underrun_cnt
);

  localparam int BEAT_W = $clog2(BURST_LEN + 1);
  localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(BURST_LEN);

  typedef enum logic [1:0] {
    WAIT_VID = 2'd0,
    ARMED    = 2'd1,
    BURST    = 2'd2
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [POS_W-1:0]  pos;
  logic [POS_W-1:0]  hp;
  logic [BEAT_W-1:0] beat_cnt;
  logic [CNT_W-1:0]  burst_cnt;
  logic              xinit;
  logic              rxvde_d;
  logic              rxvde_rise;
  logic              pop;
  logic              drop;
  logic              underrun;
  logic              burst_start;

  assign hp         = ax_dout[POS_W+8:9];
  assign rxvde_rise = rxvde & ~rxvde_d;

  assign ax_rd_en       = pop;
  assign drop_pulse     = drop;
  assign underrun_pulse = underrun;

  always_ff @(posedge fifo_clk or negedge rstbtn_n) begin
    if (!rstbtn_n) begin
      pos     <= '0;
      xinit   <= 1'b0;
      rxvde_d <= 1'b0;
    end else begin
      rxvde_d <= rxvde;
      if (vid_start) begin
        xinit <= 1'b1;
      end
      // Position saturates rather than wrapping so a long blank never re-matches old stamps.
      if (rxvde) begin
        pos <= '0;
      end else if (pos != '1) begin
        pos <= pos + POS_W'(1);
      end
    end
  end

  always_ff @(posedge fifo_clk or negedge rstbtn_n) begin
    if (!rstbtn_n) begin
      state    <= WAIT_VID;
      beat_cnt <= '0;
    end else begin
      state <= next_state;
      if (burst_start) begin
        beat_cnt <= BEAT_W'(1);
      end else if (pop && state == BURST) begin
        beat_cnt <= beat_cnt + BEAT_W'(1);
      end
    end
  end

  always_comb begin
    next_state  = state;
    pop         = 1'b0;
    drop        = 1'b0;
    underrun    = 1'b0;
    burst_start = 1'b0;
    if (vfifo_empty) begin
      next_state = WAIT_VID;
    end else begin
      case (state)
        WAIT_VID: begin
          if ((xinit || vid_start) && rxvde) begin
            next_state = ARMED;
          end
        end
        ARMED: begin
          if (!rxvde && !ax_empty) begin
            if (hp == pos) begin
              pop         = 1'b1;
              burst_start = 1'b1;
              next_state  = BURST;
            end else if (hp < pos) begin
              pop  = 1'b1;
              drop = 1'b1;
            end
          end
        end
        BURST: begin
          // A full-length burst is not an underrun even if the FIFO has drained.
          if (rxvde || beat_cnt >= BEAT_MAX) begin
            next_state = ARMED;
          end else if (ax_empty) begin
            underrun   = 1'b1;
            next_state = ARMED;
          end else if (hp == pos) begin
            pop = 1'b1;
          end else begin
            next_state = ARMED;
          end
        end
        default: next_state = WAIT_VID;
      endcase
    end
  end

  always_ff @(posedge fifo_clk or negedge rstbtn_n) begin
    if (!rstbtn_n) begin
      ade     <= 1'b0;
      aux_out <= '0;
    end else begin
      ade <= pop & ~drop;
      if (pop && !drop) begin
        aux_out <= ax_dout[8:0];
      end
    end
  end

  // A burst starting on the rxvde rising edge belongs to neither interval.
  always_ff @(posedge fifo_clk or negedge rstbtn_n) begin
    if (!rstbtn_n) begin
      burst_cnt <= '0;
      ade_num   <= '0;
    end else if (rxvde_rise) begin
      ade_num   <= burst_cnt;
      burst_cnt <= '0;
    end else if (burst_start && burst_cnt != '1) begin
      burst_cnt <= burst_cnt + CNT_W'(1);
    end
  end

`ifdef AUX_STATS_EN
  always_ff @(posedge fifo_clk or negedge rstbtn_n) begin
    if (!rstbtn_n) begin
      drop_cnt     <= '0;
      underrun_cnt <= '0;
    end else begin
      if (drop && drop_cnt != 16'hFFFF) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
      if (underrun && underrun_cnt != 16'hFFFF) begin
        underrun_cnt <= underrun_cnt + 16'd1;
      end
    end
  end
`else
  assign drop_cnt     = 16'd0;
  assign underrun_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_aux_replay_sched.sv
// Self-checking bench for aux_replay_sched: a behavioural FWFT aux FIFO, a table of
// single-word cases, and hand-written burst, underrun, abort, vfifo_empty and reset sequences.
module tb_aux_replay_sched;

`ifdef AUX_STATS_EN
  localparam int STATS_ON = 1;
`else
  localparam int STATS_ON = 0;
`endif

  logic        fifo_clk = 1'b0;
  logic        rstbtn_n;
  logic        rxvde;
  logic        vid_start;
  logic        vfifo_empty;
  logic [24:0] ax_dout;
  logic        ax_empty;
  logic        ax_rd_en;
  logic        ade;
  logic [8:0]  aux_out;
  logic [3:0]  ade_num;
  logic        drop_pulse;
  logic        underrun_pulse;
  logic [15:0] drop_cnt;
  logic [15:0] underrun_cnt;

  int errors = 0;
  int checks = 0;

  logic [24:0] fifo_mem [0:255];
  int rd_ptr = 0;
  int wr_ptr = 0;

  int         pop_log[$];
  int         ade_log[$];
  int         drop_log[$];
  int         und_log[$];
  logic [8:0] ade_aux[$];

  typedef struct {
    int         stamp;
    int         push_idx;
    logic [8:0] aux;
    int         exp_pop;
    int         exp_drop;
    int         exp_under;
    int         exp_bursts;
  } vec_t;

  vec_t vecs[4];
  int   tot_drop;
  int   tot_under;

  aux_replay_sched dut (
    .fifo_clk      (fifo_clk),
    .rstbtn_n      (rstbtn_n),
    .rxvde         (rxvde),
    .vid_start     (vid_start),
    .vfifo_empty   (vfifo_empty),
    .ax_dout       (ax_dout),
    .ax_empty      (ax_empty),
    .ax_rd_en      (ax_rd_en),
    .ade           (ade),
    .aux_out       (aux_out),
    .ade_num       (ade_num),
    .drop_pulse    (drop_pulse),
    .underrun_pulse(underrun_pulse),
    .drop_cnt      (drop_cnt),
    .underrun_cnt  (underrun_cnt)
  );

  always #5 fifo_clk = ~fifo_clk;

  assign ax_dout  = fifo_mem[rd_ptr & 255];
  assign ax_empty = (rd_ptr == wr_ptr);

  always @(posedge fifo_clk) begin
    if (ax_rd_en) rd_ptr <= rd_ptr + 1;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [8:0] aux_pat(input int i);
    return 9'((i * 37 + 11) & 511);
  endfunction

  function automatic int stat_exp(input int n);
    return n * STATS_ON;
  endfunction

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic push(input logic [24:0] w);
    fifo_mem[wr_ptr & 255] = w;
    wr_ptr++;
  endtask

  task automatic flush();
    wr_ptr = rd_ptr;
  endtask

  task automatic applyStimulus(input logic vde, input logic vs, input logic vfe);
    @(posedge fifo_clk);
    #1;
    rxvde       = vde;
    vid_start   = vs;
    vfifo_empty = vfe;
  endtask

  task automatic check_reset_outputs(input string tag);
    checkOutput({tag, "_ax_rd_en"}, ax_rd_en, 0);
    checkOutput({tag, "_ade"}, ade, 0);
    checkOutput({tag, "_aux_out"}, aux_out, 0);
    checkOutput({tag, "_ade_num"}, ade_num, 0);
    checkOutput({tag, "_drop_pulse"}, drop_pulse, 0);
    checkOutput({tag, "_underrun_pulse"}, underrun_pulse, 0);
    checkOutput({tag, "_drop_cnt"}, drop_cnt, 0);
    checkOutput({tag, "_underrun_cnt"}, underrun_cnt, 0);
  endtask

  // Blank index j corresponds to pixel position j because rxvde restarts the counter.
  task automatic run_line(input int n_act, input int n_blank, input int rise_idx,
                          input int vfe_idx, input int rst_idx, input int push_idx,
                          input logic [24:0] push_word);
    pop_log.delete();
    ade_log.delete();
    drop_log.delete();
    und_log.delete();
    ade_aux.delete();
    for (int i = 0; i < n_act; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      @(negedge fifo_clk);
      if (ax_empty) checkOutput("rd_en_while_empty", ax_rd_en, 0);
    end
    for (int j = 0; j < n_blank; j++) begin
      @(posedge fifo_clk);
      #1;
      rxvde       = (rise_idx >= 0 && j >= rise_idx);
      vid_start   = 1'b0;
      vfifo_empty = (j == vfe_idx);
      rstbtn_n    = (j != rst_idx);
      if (j == push_idx) push(push_word);
      @(negedge fifo_clk);
      if (ax_rd_en) pop_log.push_back(j);
      if (drop_pulse) drop_log.push_back(j);
      if (underrun_pulse) und_log.push_back(j);
      if (ade) begin
        ade_log.push_back(j);
        ade_aux.push_back(aux_out);
      end
      if (ax_empty) checkOutput("rd_en_while_empty", ax_rd_en, 0);
      if (j == rst_idx) check_reset_outputs("midburst_reset");
    end
  endtask

  task automatic close_line(input string tag, input int exp_num);
    applyStimulus(1'b1, 1'b0, 1'b0);
    @(negedge fifo_clk);
    applyStimulus(1'b1, 1'b0, 1'b0);
    @(negedge fifo_clk);
    checkOutput({tag, "_ade_num"}, ade_num, exp_num);
  endtask

  task automatic check_burst(input string tag, input int off, input int stamp0,
                             input int n, input int aux0);
    for (int i = 0; i < n; i++) begin
      if (off + i < pop_log.size()) checkOutput({tag, "_pop_pos"}, pop_log[off+i], stamp0 + i);
      else checkOutput({tag, "_pop_count"}, pop_log.size(), off + n);
      if (off + i < ade_log.size()) begin
        checkOutput({tag, "_ade_pos"}, ade_log[off+i], stamp0 + i + 1);
        checkOutput({tag, "_aux"}, ade_aux[off+i], aux_pat(aux0 + i));
      end else begin
        checkOutput({tag, "_ade_count"}, ade_log.size(), off + n);
      end
    end
  endtask

  initial begin
    vecs[0] = '{stamp: 50,  push_idx: 60, aux: 9'h0A5, exp_pop: 60, exp_drop: 1, exp_under: -1, exp_bursts: 0};
    vecs[1] = '{stamp: 80,  push_idx: 10, aux: 9'h15A, exp_pop: 80, exp_drop: 0, exp_under: 81, exp_bursts: 1};
    vecs[2] = '{stamp: 0,   push_idx: 0,  aux: 9'h1FF, exp_pop: 0,  exp_drop: 0, exp_under: 1,  exp_bursts: 1};
    vecs[3] = '{stamp: 300, push_idx: 5,  aux: 9'h033, exp_pop: -1, exp_drop: 0, exp_under: -1, exp_bursts: 0};
    tot_drop  = 0;
    tot_under = 0;

    for (int i = 0; i < 256; i++) fifo_mem[i] = '0;
    rstbtn_n    = 1'b1;
    rxvde       = 1'b0;
    vid_start   = 1'b0;
    vfifo_empty = 1'b0;
    #2;
    rstbtn_n = 1'b0;
    repeat (3) @(posedge fifo_clk);
    @(negedge fifo_clk);
    check_reset_outputs("por");
    @(posedge fifo_clk);
    #1;
    rstbtn_n = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);

    // One contiguous 32-word burst.
    for (int i = 0; i < 32; i++) push({16'(100 + i), aux_pat(i)});
    run_line(64, 200, -1, -1, -1, -1, 25'd0);
    checkOutput("single_pop_count", pop_log.size(), 32);
    checkOutput("single_ade_count", ade_log.size(), 32);
    check_burst("single", 0, 100, 32, 0);
    checkOutput("single_drops", drop_log.size(), 0);
    checkOutput("single_underruns", und_log.size(), 0);
    close_line("single", 1);

    // Two bursts separated by an 8-cycle gap.
    for (int i = 0; i < 32; i++) push({16'(100 + i), aux_pat(i)});
    for (int i = 0; i < 32; i++) push({16'(140 + i), aux_pat(32 + i)});
    run_line(64, 200, -1, -1, -1, -1, 25'd0);
    checkOutput("double_pop_count", pop_log.size(), 64);
    checkOutput("double_ade_count", ade_log.size(), 64);
    check_burst("double_b1", 0, 100, 32, 0);
    check_burst("double_b2", 32, 140, 32, 32);
    checkOutput("double_underruns", und_log.size(), 0);
    close_line("double", 2);

    // Table of single-word cases: stale drop, late match, position zero, never reached.
    for (int v = 0; v < 4; v++) begin
      run_line(8, 120, -1, -1, -1, vecs[v].push_idx, {16'(vecs[v].stamp), vecs[v].aux});
      checkOutput("vec_pop_count", pop_log.size(), (vecs[v].exp_pop >= 0) ? 1 : 0);
      if (vecs[v].exp_pop >= 0 && pop_log.size() > 0)
        checkOutput("vec_pop_pos", pop_log[0], vecs[v].exp_pop);
      checkOutput("vec_drop_count", drop_log.size(), vecs[v].exp_drop);
      if (vecs[v].exp_pop >= 0 && vecs[v].exp_drop == 0) begin
        checkOutput("vec_ade_count", ade_log.size(), 1);
        if (ade_log.size() > 0) begin
          checkOutput("vec_ade_pos", ade_log[0], vecs[v].exp_pop + 1);
          checkOutput("vec_aux", ade_aux[0], vecs[v].aux);
        end
      end else begin
        checkOutput("vec_ade_count", ade_log.size(), 0);
      end
      checkOutput("vec_under_count", und_log.size(), (vecs[v].exp_under >= 0) ? 1 : 0);
      if (vecs[v].exp_under >= 0 && und_log.size() > 0)
        checkOutput("vec_under_pos", und_log[0], vecs[v].exp_under);
      checkOutput("vec_fifo_left", wr_ptr - rd_ptr, (vecs[v].exp_pop < 0) ? 1 : 0);
      tot_drop  += vecs[v].exp_drop;
      tot_under += (vecs[v].exp_under >= 0) ? 1 : 0;
      checkOutput("vec_drop_cnt", drop_cnt, stat_exp(tot_drop));
      checkOutput("vec_underrun_cnt", underrun_cnt, stat_exp(tot_under));
      flush();
      close_line("vec", vecs[v].exp_bursts);
    end

    // Short burst: 20 words then empty, then a lone word proves the block re-armed.
    for (int i = 0; i < 20; i++) push({16'(100 + i), aux_pat(100 + i)});
    run_line(8, 200, -1, -1, -1, 130, {16'd150, 9'h0C3});
    checkOutput("short_pop_count", pop_log.size(), 21);
    check_burst("short", 0, 100, 20, 100);
    if (pop_log.size() > 20) checkOutput("short_rearm_pop", pop_log[20], 150);
    checkOutput("short_under_count", und_log.size(), 2);
    if (und_log.size() > 0) checkOutput("short_under_pos", und_log[0], 120);
    if (und_log.size() > 1) checkOutput("short_under_pos2", und_log[1], 151);
    tot_under += 2;
    checkOutput("short_underrun_cnt", underrun_cnt, stat_exp(tot_under));
    close_line("short", 2);

    // rxvde rises after five beats: the rest of the words must stay queued.
    for (int i = 0; i < 32; i++) push({16'(100 + i), aux_pat(200 + i)});
    run_line(8, 115, 105, -1, -1, -1, 25'd0);
    checkOutput("abort_pop_count", pop_log.size(), 5);
    checkOutput("abort_ade_count", ade_log.size(), 5);
    check_burst("abort", 0, 100, 5, 200);
    checkOutput("abort_under_count", und_log.size(), 0);
    checkOutput("abort_fifo_left", wr_ptr - rd_ptr, 27);
    close_line("abort", 1);
    flush();

    // vfifo_empty on the exact match cycle parks the block until the next rxvde.
    push({16'd100, 9'h111});
    run_line(8, 140, -1, 100, -1, -1, 25'd0);
    checkOutput("vfe_pop_count", pop_log.size(), 0);
    checkOutput("vfe_ade_count", ade_log.size(), 0);
    checkOutput("vfe_drop_count", drop_log.size(), 0);
    checkOutput("vfe_fifo_left", wr_ptr - rd_ptr, 1);
    close_line("vfe", 0);
    run_line(8, 140, -1, -1, -1, -1, 25'd0);
    checkOutput("vfe_resume_pop_count", pop_log.size(), 1);
    if (pop_log.size() > 0) checkOutput("vfe_resume_pop_pos", pop_log[0], 100);
    if (ade_aux.size() > 0) checkOutput("vfe_resume_aux", ade_aux[0], 9'h111);
    close_line("vfe_resume", 1);

    // Reset after ten beats; nothing may pop until a fresh vid_start plus rxvde.
    for (int i = 0; i < 32; i++) push({16'(100 + i), aux_pat(300 + i)});
    run_line(8, 150, -1, -1, 110, -1, 25'd0);
    checkOutput("rst_pop_count", pop_log.size(), 10);
    checkOutput("rst_ade_count", ade_log.size(), 9);
    checkOutput("rst_fifo_left", wr_ptr - rd_ptr, 22);
    run_line(8, 150, -1, -1, -1, -1, 25'd0);
    checkOutput("rst_novid_pop_count", pop_log.size(), 0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    run_line(8, 150, -1, -1, -1, -1, 25'd0);
    checkOutput("rst_resume_pop_count", pop_log.size(), 22);
    check_burst("rst_resume", 0, 110, 22, 310);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aux_replay_sched.md
Name: aux_replay_sched

Overview:
- Receive-side audio/aux scheduler. Sits between the receive aux FIFO (25-bit words {pos[15:0], aux[8:0]}) and the TMDS encoder's aux path in the fifo_clk domain.
- Keeps a pixel-position counter that restarts on every regenerated rxvde. It pops each aux word when the counter equals the word's stamped position, and replays it as a registered ADE beat with aux data.
- It also drops stale words, flags underruns and reports bursts per blanking interval.

Parameters:
- POS_W, 16, width of the position counter and of the word position field.
- BURST_LEN, 32, maximum number of consecutive ADE beats per burst.
- CNT_W, 4, width of ade_num.

Ports:
- fifo_clk  in  1  pixel clock (74.25 MHz); the block's only clock.
- rstbtn_n  in  1  asynchronous, active-low reset.
- rxvde  in  1  regenerated video data enable from the output timing.
- vid_start  in  1  pulse when the video receive FIFO delivers its first word.
- vfifo_empty  in  1  video receive FIFO empty.
- ax_dout  in  25  aux FIFO head, first-word-fall-through: {pos[24:9], aux[8:0]}.
- ax_empty  in  1  aux FIFO empty.
- ax_rd_en  out  1  aux FIFO pop (combinational).
- ade  out  1  registered aux data enable to the encoder.
- aux_out  out  9  registered aux data {aux2[3:0], aux1[3:0], aux0[2]}.
- ade_num  out  CNT_W  bursts counted in the previous blanking interval.
- drop_pulse  out  1  one-cycle pulse per stale word discarded.
- underrun_pulse  out  1  one-cycle pulse when a burst ends short because the FIFO was empty.
- drop_cnt  out  16  saturating count of dropped words (feature-dependent).
- underrun_cnt  out  16  saturating count of underruns (feature-dependent).

Behaviour:
- Reset: all outputs 0, pos=0, xinit=0, state=WAIT_VID, burst counter=0, bursts-this-interval=0.
- pos counter: pos <= 0 in any cycle with rxvde=1; otherwise pos <= pos+1, saturating at all-ones (no wrap).
- xinit: set by vid_start and never cleared except by reset.
- vfifo_empty=1 forces WAIT_VID on the next edge from any state. xinit is held. ade is forced to 0 on that edge.
- Word position hp = ax_dout[24:9].
- States:
  - WAIT_VID: go to ARMED when xinit=1 (or vid_start=1 this cycle) and rxvde=1. No pops.
  - ARMED, evaluated with rxvde=0 and ax_empty=0:
    - hp==pos: pop, go to BURST, beat count=1.
    - hp<pos: stale word; pop, drop_pulse=1, stay in ARMED.
    - hp>pos: wait.
    - With rxvde=1 or ax_empty=1: no pop.
  - BURST:
    - rxvde=1: abort to ARMED, no pop, no underrun.
    - ax_empty=1: underrun_pulse=1, go to ARMED.
    - hp==pos and count<BURST_LEN: pop, count+1.
    - hp!=pos (next burst not contiguous) or count==BURST_LEN: go to ARMED without popping.
- Data latency:
  - A pop in cycle t gives ade=1 and aux_out=ax_dout[8:0] (captured at t) in cycle t+1.
  - No pop in cycle t gives ade=0 in t+1. aux_out holds its last value.
  - Drops never raise ade.
- ax_rd_en=1 only in pop cycles. It is never asserted when ax_empty=1.
- ade_num:
  - The burst counter increments on each ARMED->BURST transition, saturating at all-ones.
  - On an rxvde rising edge (rxvde=1 with the previous cycle 0): ade_num <= counter, and the counter is cleared.
  - If a burst starts in the same cycle as the edge, the cleared counter takes precedence; that burst is not counted.
- Simultaneous vfifo_empty and a pop condition: vfifo_empty wins. No pop occurs.

Optional Feature:
- Macro AUX_STATS_EN.
- Defined:
  - drop_cnt increments on each drop_pulse; underrun_cnt increments on each underrun_pulse.
  - Both saturate at 16'hFFFF and are cleared only by reset.
- Undefined: drop_cnt and underrun_cnt are tied to 0 and no counter logic exists. drop_pulse and underrun_pulse are unaffected.

Test Plan:
- Reset with rstbtn_n=0 mid-burst (ade=1, 10 beats issued) -> same cycle: outputs 0, ax_rd_en=0; after release state is WAIT_VID, and no pop occurs until a new vid_start plus rxvde.
- vid_start, rxvde high 1280 cycles then low; FIFO holds 32 words stamped pos=100..131 -> 32 pops at pos 100..131; ade high for pos 101..132; aux_out matches word order; ade_num=1 after the next rxvde rise.
- FIFO holds 32 words stamped 100..131 then 32 stamped 140..171 -> two distinct ade bursts (32 beats each) with 8 idle cycles between them; ade_num=2 after the next rxvde rise.
- Head word stamped pos=50 arrives when pos=60 -> popped with drop_pulse=1 and no ade. With AUX_STATS_EN, drop_cnt=1; without it, drop_cnt=0.
- Burst of 32 beats expected but only 20 words present -> 20 ade beats; underrun_pulse once, on the cycle after the 20th pop; state is ARMED.
- rxvde rises after 5 beats of a burst -> no further pops; ade low from the second cycle after the rise; the remaining words stay in the FIFO.
- vfifo_empty asserted with hp==pos -> no pop; state is WAIT_VID; the burst resumes only after rxvde.
